// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode-stage interlock for the five-stage MIPS pipeline using
//               per-GPR countdowns, an MDU busy counter and an EPC/eret window.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int TNEW_W   = 2,
    parameter int MUL_LAT  = 5,
    parameter int DIV_LAT  = 10,
    parameter int CP0_WIN  = 2,
    parameter int EPC_ADDR = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    d_valid,
    input  logic [$clog2(NREG)-1:0] d_rs,
    input  logic [$clog2(NREG)-1:0] d_rt,
    input  logic [TNEW_W-1:0]       d_tuse_rs,
    input  logic [TNEW_W-1:0]       d_tuse_rt,
    input  logic                    d_rfwr,
    input  logic [$clog2(NREG)-1:0] d_a3,
    input  logic [TNEW_W-1:0]       d_tnew,
    input  logic                    d_md_start,
    input  logic                    d_md_div,
    input  logic                    d_md_use,
    input  logic                    d_mtc0,
    input  logic [4:0]              d_cp0_rd,
    input  logic                    d_eret,
    input  logic                    flush,
    output logic                    stall,
    output logic                    mdu_busy,
    output logic [NREG-1:0]         pending
);

    localparam int c_AW      = $clog2(NREG);
    localparam int c_MDU_MAX = ((DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT) + 1;
    localparam int c_MDU_W   = $clog2(c_MDU_MAX + 1);
    localparam int c_CP0_W   = (CP0_WIN < 1) ? 1 : $clog2(CP0_WIN + 1);

    localparam logic [c_MDU_W-1:0] c_MUL_LOAD = c_MDU_W'(MUL_LAT + 1);
    localparam logic [c_MDU_W-1:0] c_DIV_LOAD = c_MDU_W'(DIV_LAT + 1);
    localparam logic [c_CP0_W-1:0] c_CP0_LOAD = c_CP0_W'(CP0_WIN);
    localparam logic [4:0]         c_EPC      = 5'(EPC_ADDR);

    logic [TNEW_W-1:0]  r_cnt [NREG];
    logic [c_MDU_W-1:0] r_mdu_cnt;
    logic [c_CP0_W-1:0] r_cp0_cnt;

    logic w_stall_rs;
    logic w_stall_rt;
    logic w_stall_mdu;
    logic w_stall_eret;
    logic w_issue;

    // A source stalls only while its producer is further from forwardable
    // than the consumer is from needing the value.
    always_comb begin
        w_stall_rs   = d_valid && (d_rs != '0) && (r_cnt[d_rs] > d_tuse_rs);
        w_stall_rt   = d_valid && (d_rt != '0) && (r_cnt[d_rt] > d_tuse_rt);
        w_stall_mdu  = d_valid && d_md_use && (r_mdu_cnt != '0);
        w_stall_eret = d_valid && d_eret && (r_cp0_cnt != '0);
    end

    assign stall    = w_stall_rs | w_stall_rt | w_stall_mdu | w_stall_eret;
    assign w_issue  = d_valid & ~stall & ~flush;
    assign mdu_busy = (r_mdu_cnt != '0);

    // Entry 0 is held at zero so $zero never reports a pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if ((i == 0) || flush) begin
                    r_cnt[i] <= '0;
                end else if (w_issue && d_rfwr && (d_a3 == c_AW'(i))) begin
                    r_cnt[i] <= d_tnew;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - TNEW_W'(1);
                end
            end
        end
    end

    // An MDU operation already started runs to completion across a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mdu_cnt <= '0;
        end else if (w_issue && d_md_start) begin
            r_mdu_cnt <= d_md_div ? c_DIV_LOAD : c_MUL_LOAD;
        end else if (r_mdu_cnt != '0) begin
            r_mdu_cnt <= r_mdu_cnt - c_MDU_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cp0_cnt <= '0;
        end else if (flush) begin
            r_cp0_cnt <= '0;
        end else if (w_issue && d_mtc0 && (d_cp0_rd == c_EPC)) begin
            r_cp0_cnt <= c_CP0_LOAD;
        end else if (r_cp0_cnt != '0) begin
            r_cp0_cnt <= r_cp0_cnt - c_CP0_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pending[gi] = 1'b0;
            end else begin : g_reg
                assign pending[gi] = (r_cnt[gi] != '0);
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised decode-stage interlock unit for the five-stage MIPS pipeline.
- Decode and the pipeline registers no longer re-decode E and M instructions. Instead, a per-register countdown scoreboard tracks in-flight destination writes.
- Also includes an internal MDU busy counter with configurable multiply/divide latency and a CP0 EPC write window for `eret`.
- Asserts `stall` to freeze F/D and insert a bubble into E.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is never tracked.
- TNEW_W, 2, width of tuse/tnew and the per-register countdown.
- MUL_LAT, 5, MDU busy cycles for mult/multu.
- DIV_LAT, 10, MDU busy cycles for div/divu.
- CP0_WIN, 2, cycles an issued `mtc0` to EPC blocks `eret` (E+M residency).
- EPC_ADDR, 14, CP0 register number of EPC.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset
- d_valid  input  1  D holds a real instruction (0 = bubble)
- d_rs  input  $clog2(NREG)  D source register rs
- d_rt  input  $clog2(NREG)  D source register rt
- d_tuse_rs  input  TNEW_W  cycles until rs is consumed
- d_tuse_rt  input  TNEW_W  cycles until rt is consumed
- d_rfwr  input  1  D instruction writes a GPR
- d_a3  input  $clog2(NREG)  D destination register
- d_tnew  input  TNEW_W  cycles, counted from entry into E, until the result is forwardable
- d_md_start  input  1  D is mult/multu/div/divu
- d_md_div  input  1  qualifies d_md_start: 1 = divide latency
- d_md_use  input  1  D is any of mfhi/mflo/mthi/mtlo or an MDU start
- d_mtc0  input  1  D is mtc0
- d_cp0_rd  input  5  CP0 destination of D mtc0
- d_eret  input  1  D is eret
- flush  input  1  exception/eret pipeline flush this cycle
- stall  output  1  combinational interlock to F/D/E
- mdu_busy  output  1  MDU counter non-zero
- pending  output  NREG  bit i = GPR i has a non-zero countdown

Behaviour:
- `issue = d_valid & ~stall & ~flush`. The D instruction enters E at the next rising edge only when `issue` is 1.
- State: `cnt[i]` (TNEW_W bits, i = 1..NREG-1), `mdu_cnt` (wide enough for DIV_LAT+1), `cp0_cnt` (wide enough for CP0_WIN).
- Reset: asynchronous, active-low. All counters go to 0, so `pending = 0`, `mdu_busy = 0` and `stall = 0` while reset is held and after release.
- Every edge, each `cnt[i]` decrements by 1, saturating at 0.
- On issue with `d_rfwr` and `d_a3 != 0`, `cnt[d_a3]` loads `d_tnew`. The load wins over the decrement (newest writer supersedes older ones).
- `d_a3 == 0` or `d_rfwr == 0`: no scoreboard change.
- Stall terms are combinational from the current state and D inputs, all gated by `d_valid`:
  - rs: `d_rs != 0 & cnt[d_rs] > d_tuse_rs`
  - rt: `d_rt != 0 & cnt[d_rt] > d_tuse_rt`
  - mdu: `d_md_use & mdu_cnt != 0`
  - eret: `d_eret & cp0_cnt != 0`
  - `stall` is the OR of all four terms.
- MDU counter:
  - On issue with `d_md_start`, `mdu_cnt` loads MUL_LAT+1, or DIV_LAT+1 when `d_md_div` (the +1 covers the start cycle in E).
  - Otherwise it decrements to 0.
  - `mdu_busy = (mdu_cnt != 0)`.
- CP0 window:
  - On issue with `d_mtc0 & d_cp0_rd == EPC_ADDR`, `cp0_cnt` loads CP0_WIN.
  - Otherwise it decrements, saturating at 0.
- Flush:
  - At the edge, all `cnt[i]` and `cp0_cnt` clear to 0; no issue happens that cycle.
  - `mdu_cnt` keeps counting down, because an operation already started completes.
  - `stall` is still computed during flush; downstream ignores it.
- A stall and a decrement in the same cycle are normal: the stall releases once the countdown falls to ≤ tuse.
- Reset asserted mid-MDU-operation clears `mdu_cnt` immediately.
- Reset asserted mid-stall drops `stall` in the same cycle.
- `pending[0]` is always 0.

Test Plan:
- Load-use: issue lw to $8 (tnew=2), next cycle D reads $8 with tuse=0 → `stall` = 1 for exactly 2 cycles, then 0; `pending[8]` 1→0 after 2 edges.
- ALU to branch: issue addu to $5 (tnew=1), D is beq reading $5 with tuse=0 → 1 stall cycle. Same D with tuse=1 → no stall.
- Overwrite: issue lw $3 (tnew=2), then addu $3 (tnew=1) the next cycle → `cnt[3]` = 1 after the second issue. Reader with tuse=0 stalls 1 cycle, not 2.
- MDU: issue div (DIV_LAT=10), then mflo in D → `stall` held for 11 cycles and `mdu_busy` high for 11 cycles. An assertion of `flush` during this window does not shorten it.
- EPC: issue mtc0 $14 then eret in D → `stall` 2 cycles. mtc0 to $12 then eret → no stall.
- Reset/flush: with `cnt[7]`=2 and `mdu_cnt`=6, pulse `flush` → `pending` = 0 and `mdu_cnt` = 5 next cycle. Then assert `reset` low → `mdu_busy` and `stall` go to 0 asynchronously.
